// File: rtl/cp0_regfile.sv
// cp0_regfile -- Coprocessor-0 register file at the MEM/WB boundary.
//
// Holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId. It records
// exceptions and ERET, runs the Count/Compare timer, and raises int_pending
// for the exception unit.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cp0_write_en        MTC0 commit (data cp0_write_data, address cp0_addr)
//   cp0_read_en         MFC0 read; cp0_read_data is combinational
//   cp0_addr            {rd[4:0], sel[2:0]}
//   hw_int              external interrupt lines (level, sampled each cycle)
//   exc_en/exc_code/exc_pc/exc_delay_slot/exc_badvaddr   exception commit
//   eret_en             ERET commit
//   status/cause/epc    current register values
//   int_pending         enabled, unmasked interrupt outstanding
//
// Build option: define CP0_TIMER_INT_EN to build the Count==Compare
// comparator and Cause.TI. Without it, TI is constant 0 and Compare is a
// plain read/write register.

module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_write_en,
    input  logic        cp0_read_en,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] cp0_write_data,
    input  logic [5:0]  hw_int,
    input  logic        exc_en,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_en,
    output logic [31:0] cp0_read_data,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        int_pending
);

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;
    localparam logic [7:0] ADDR_PRID     = 8'h78;

    // Only the writable/hardware-updated fields are stored; constant bits
    // are supplied when the full registers are assembled below.
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [4:0]  exc_code_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        tick_q;
    logic        ti;

    // Exception beats ERET beats MTC0; a losing access is dropped.
    logic do_eret;
    logic wr_ok;
    logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;

    assign do_eret    = eret_en & ~exc_en;
    assign wr_ok      = cp0_write_en & ~exc_en & ~eret_en;
    assign wr_status  = wr_ok && (cp0_addr == ADDR_STATUS);
    assign wr_cause   = wr_ok && (cp0_addr == ADDR_CAUSE);
    assign wr_epc     = wr_ok && (cp0_addr == ADDR_EPC);
    assign wr_count   = wr_ok && (cp0_addr == ADDR_COUNT);
    assign wr_compare = wr_ok && (cp0_addr == ADDR_COMPARE);

    // Status: IM, EXL, IE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else if (exc_en) begin
            exl_q <= 1'b1;
        end else if (do_eret) begin
            exl_q <= 1'b0;
        end else if (wr_status) begin
            im_q  <= cp0_write_data[15:8];
            exl_q <= cp0_write_data[1];
            ie_q  <= cp0_write_data[0];
        end
    end

    // Cause: BD, ExcCode, IP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
        end else begin
            ip_hw_q <= hw_int;
            if (exc_en) begin
                exc_code_q <= exc_code;
                if (!exl_q) begin
                    bd_q <= exc_delay_slot;
                end
            end else if (wr_cause) begin
                ip_sw_q <= cp0_write_data[9:8];
            end
        end
    end

    // EPC and BadVAddr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else if (exc_en) begin
            if (!exl_q) begin
                epc_q <= exc_delay_slot ? (exc_pc - 32'd4) : exc_pc;
            end
            if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
                badvaddr_q <= exc_badvaddr;
            end
        end else if (wr_epc) begin
            epc_q <= cp0_write_data;
        end
    end

    // Count runs at half clock rate; a Count write overrides the increment
    // but leaves the tick phase alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q  <= 1'b0;
            count_q <= '0;
        end else begin
            tick_q <= ~tick_q;
            if (wr_count) begin
                count_q <= cp0_write_data;
            end else if (tick_q) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_q <= '0;
        end else if (wr_compare) begin
            compare_q <= cp0_write_data;
        end
    end

`ifdef CP0_TIMER_INT_EN
    // TI is sticky; a Compare write clears it and wins over a coincident match.
    logic ti_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ti_q <= 1'b0;
        end else if (wr_compare) begin
            ti_q <= 1'b0;
        end else if (count_q == compare_q) begin
            ti_q <= 1'b1;
        end
    end

    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    // IP[15] merges the sampled hw_int[5] with TI.
    assign cause  = {bd_q, ti, 14'b0, ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q,
                     1'b0, exc_code_q, 2'b0};
    assign epc    = epc_q;

    assign int_pending = ie_q & ~exl_q & (|(cause[15:8] & im_q));

    always_comb begin
        cp0_read_data = '0;
        if (cp0_read_en) begin
            case (cp0_addr)
                ADDR_BADVADDR: cp0_read_data = badvaddr_q;
                ADDR_COUNT:    cp0_read_data = count_q;
                ADDR_COMPARE:  cp0_read_data = compare_q;
                ADDR_STATUS:   cp0_read_data = status;
                ADDR_CAUSE:    cp0_read_data = cause;
                ADDR_EPC:      cp0_read_data = epc_q;
                ADDR_PRID:     cp0_read_data = PRID_VALUE;
                default:       cp0_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile -- directed-vector scoreboard bench for cp0_regfile.
// Each MFC0 issued by the stimulus pushes its expected result; the monitor
// pops and compares at the falling edge whenever cp0_read_en is high.

module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cp0_write_en = 1'b0;
    logic        cp0_read_en = 1'b0;
    logic [7:0]  cp0_addr = '0;
    logic [31:0] cp0_write_data = '0;
    logic [5:0]  hw_int = '0;
    logic        exc_en = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_delay_slot = 1'b0;
    logic [31:0] exc_badvaddr = '0;
    logic        eret_en = 1'b0;
    logic [31:0] cp0_read_data;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        int_pending;

`ifdef CP0_TIMER_INT_EN
    localparam logic [31:0] TI_BITS = 32'h4000_8000;
`else
    localparam logic [31:0] TI_BITS = 32'h0000_0000;
`endif

    cp0_regfile #(.PRID_VALUE(32'h0000_4220)) dut (
        .clk(clk), .rst(rst),
        .cp0_write_en(cp0_write_en), .cp0_read_en(cp0_read_en),
        .cp0_addr(cp0_addr), .cp0_write_data(cp0_write_data),
        .hw_int(hw_int),
        .exc_en(exc_en), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_delay_slot(exc_delay_slot), .exc_badvaddr(exc_badvaddr),
        .eret_en(eret_en),
        .cp0_read_data(cp0_read_data), .status(status), .cause(cause),
        .epc(epc), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    // Reference tick phase: Count advances on edges where this is 1.
    logic m_tick;
    always @(posedge clk or posedge rst) begin
        if (rst) m_tick <= 1'b0;
        else     m_tick <= ~m_tick;
    end

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [31:0] exp;
        bit          chk_ip;
        bit          exp_ip;
    } entry_t;

    entry_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Monitor
    always @(negedge clk) begin
        if (!rst && cp0_read_en) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read addr=%h got=%h required=none", cp0_addr, cp0_read_data);
            end else begin
                entry_t e;
                e = sb.pop_front();
                vectors++;
                if (cp0_read_data !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s read_data got=%h required=%h", e.name, cp0_read_data, e.exp);
                end
                if (e.addr == 8'h60 || e.addr == 8'h68 || e.addr == 8'h70) begin
                    logic [31:0] direct;
                    direct = (e.addr == 8'h60) ? status : (e.addr == 8'h68) ? cause : epc;
                    vectors++;
                    if (direct !== e.exp) begin
                        miscompares++;
                        $display("FAIL %s port got=%h required=%h", e.name, direct, e.exp);
                    end
                end
                if (e.chk_ip) begin
                    vectors++;
                    if (int_pending !== e.exp_ip) begin
                        miscompares++;
                        $display("FAIL %s int_pending got=%b required=%b", e.name, int_pending, e.exp_ip);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_ip(input logic [7:0] a, input logic [31:0] exp, input string name,
                         input bit chk_ip, input bit exp_ip);
        entry_t e;
        e.name = name; e.addr = a; e.exp = exp; e.chk_ip = chk_ip; e.exp_ip = exp_ip;
        sb.push_back(e);
        cp0_read_en = 1'b1;
        cp0_addr = a;
        step();
        cp0_read_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
        rd_ip(a, exp, name, 1'b0, 1'b0);
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        cp0_write_en = 1'b1;
        cp0_addr = a;
        cp0_write_data = d;
        step();
        cp0_write_en = 1'b0;
    endtask

    task automatic set_exc(input logic [31:0] pc, input logic ds, input logic [4:0] code,
                           input logic [31:0] bad);
        exc_en = 1'b1;
        exc_pc = pc;
        exc_delay_slot = ds;
        exc_code = code;
        exc_badvaddr = bad;
    endtask

    task automatic clr_exc();
        exc_en = 1'b0;
        exc_pc = '0;
        exc_delay_slot = 1'b0;
        exc_code = '0;
        exc_badvaddr = '0;
    endtask

    initial begin
        logic t;
        int   n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rd_ip(8'h48, 32'h0, "count_reset", 1'b1, 1'b0);
        rd(8'h60, 32'h0040_0000, "status_reset");
        rd(8'h78, 32'h0000_4220, "prid");
        mtc0(8'h58, 32'hFFFF_0000);
        rd(8'h68, 32'h0, "cause_reset");
        rd(8'h70, 32'h0, "epc_reset");
        rd(8'h40, 32'h0, "badvaddr_reset");

        // Write masks and unmapped address
        mtc0(8'h60, 32'hFFFF_FFFF);
        rd_ip(8'h60, 32'h0040_FF03, "status_mask", 1'b1, 1'b0);
        mtc0(8'h68, 32'hFFFF_FFFF);
        rd_ip(8'h68, 32'h0000_0300, "cause_mask", 1'b1, 1'b0);
        mtc0(8'h50, 32'h1234_5678);
        rd(8'h50, 32'h0, "unmapped");
        mtc0(8'h60, 32'h0);
        mtc0(8'h68, 32'h0);
        rd(8'h60, 32'h0040_0000, "status_clear");

        // Exception in delay slot, AdEL
        set_exc(32'hBFC0_0100, 1'b1, 5'd4, 32'h1);
        step();
        clr_exc();
        rd(8'h70, 32'hBFC0_00FC, "exc1_epc");
        rd(8'h68, 32'h8000_0010, "exc1_cause");
        rd(8'h40, 32'h0000_0001, "exc1_badvaddr");
        rd(8'h60, 32'h0040_0002, "exc1_status");

        // Nested exception with EXL=1: EPC/BD hold, BadVAddr untouched
        set_exc(32'h0000_0200, 1'b0, 5'd12, 32'h55);
        step();
        clr_exc();
        rd(8'h70, 32'hBFC0_00FC, "exc2_epc");
        rd(8'h68, 32'h8000_0030, "exc2_cause");
        rd(8'h40, 32'h0000_0001, "exc2_badvaddr");

        eret_en = 1'b1;
        step();
        eret_en = 1'b0;
        rd(8'h60, 32'h0040_0000, "eret_status");

        // Exception beats MTC0 EPC
        set_exc(32'h0000_0400, 1'b0, 5'd5, 32'hDEAD_BEEF);
        cp0_write_en = 1'b1; cp0_addr = 8'h70; cp0_write_data = 32'h1234;
        step();
        clr_exc();
        cp0_write_en = 1'b0;
        rd(8'h70, 32'h0000_0400, "exc_vs_wr_epc");
        rd(8'h68, 32'h0000_0014, "exc3_cause");
        rd(8'h40, 32'hDEAD_BEEF, "exc3_badvaddr");
        rd(8'h60, 32'h0040_0002, "exc3_status");

        // ERET beats MTC0 Status
        eret_en = 1'b1;
        cp0_write_en = 1'b1; cp0_addr = 8'h60; cp0_write_data = 32'hFFFF_FFFF;
        step();
        eret_en = 1'b0;
        cp0_write_en = 1'b0;
        rd(8'h60, 32'h0040_0000, "eret_vs_wr_status");

        mtc0(8'h70, 32'h0000_1234);
        rd(8'h70, 32'h0000_1234, "epc_write");

        // Count write and wrap
        mtc0(8'h48, 32'hFFFF_FFFF);
        t = m_tick;
        rd(8'h48, 32'hFFFF_FFFF, "count_write");
        rd(8'h48, t ? 32'h0 : 32'hFFFF_FFFF, "count_phase");
        rd(8'h48, 32'h0, "count_wrap");

        // Hardware interrupt through IM[10]
        mtc0(8'h60, 32'h0040_0401);
        rd_ip(8'h60, 32'h0040_0401, "int_status", 1'b1, 1'b0);
        hw_int = 6'b000001;
        rd_ip(8'h68, 32'h0000_0014, "int_lag", 1'b1, 1'b0);
        rd_ip(8'h68, 32'h0000_0414, "int_sampled", 1'b1, 1'b1);
        mtc0(8'h60, 32'h0040_0403);
        rd_ip(8'h60, 32'h0040_0403, "int_exl_mask", 1'b1, 1'b0);
        hw_int = 6'b000000;

        // Timer
        mtc0(8'h60, 32'h0040_8001);
        mtc0(8'h48, 32'h0);
        mtc0(8'h58, 32'd10);
`ifdef CP0_TIMER_INT_EN
        n = 0;
        while (n <= 40) begin
            step();
            n++;
            if (int_pending === 1'b1) break;
        end
        vectors++;
        if (n < 19 || n > 20) begin
            miscompares++;
            $display("FAIL timer_latency got=%0d edges required=19..20", n);
        end
        rd_ip(8'h68, 32'h4000_8014, "timer_ti", 1'b1, 1'b1);
        mtc0(8'h58, 32'd10);
        rd_ip(8'h68, 32'h0000_0014, "timer_clear", 1'b1, 1'b0);
`else
        n = 0;
        repeat (30) step();
        rd_ip(8'h68, 32'h0000_0014, "no_timer_ti", 1'b1, 1'b0);
        rd(8'h58, 32'd10, "compare_rw");
`endif

        // Reset mid-operation drops a pending write
        mtc0(8'h70, 32'h0000_ABCD);
        cp0_write_en = 1'b1; cp0_addr = 8'h60; cp0_write_data = 32'hFFFF_FFFF;
        #3 rst = 1'b1;
        step();
        cp0_write_en = 1'b0;
        rst = 1'b0;
        rd_ip(8'h48, 32'h0, "rst2_count", 1'b1, 1'b0);
        rd(8'h60, 32'h0040_0000, "rst2_status");
        rd(8'h70, 32'h0, "rst2_epc");
        rd(8'h68, TI_BITS, "rst2_cause");

        step();
        step();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d left required=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
